// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b (mod 2^WIDTH) with final borrow.
// The per-bit full subtractor is built structurally from nand_gate/not_gate cells.
// The sequencing FSM and shift registers are behavioural.

// Two-input NAND cell.
module nand_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

// Inverter cell.
module not_gate (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

// Full subtractor: d = ai ^ bi ^ bin, bout = (~ai & bi) | (~(ai ^ bi) & bin).
module serial_subtractor_cell (
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic n1, n2, n3, t;
  logic m1, m2, m3;
  logic nai, nt, p, q;

  // t = ai ^ bi
  nand_gate u_n1 (.a(ai), .b(bi), .y(n1));
  nand_gate u_n2 (.a(ai), .b(n1), .y(n2));
  nand_gate u_n3 (.a(bi), .b(n1), .y(n3));
  nand_gate u_t  (.a(n2), .b(n3), .y(t));

  // d = t ^ bin
  nand_gate u_m1 (.a(t),   .b(bin), .y(m1));
  nand_gate u_m2 (.a(t),   .b(m1),  .y(m2));
  nand_gate u_m3 (.a(bin), .b(m1),  .y(m3));
  nand_gate u_d  (.a(m2),  .b(m3),  .y(d));

  // bout = nand(nand(~ai, bi), nand(~t, bin))
  not_gate  u_nai (.a(ai), .y(nai));
  not_gate  u_nt  (.a(t),  .y(nt));
  nand_gate u_p   (.a(nai), .b(bi),  .y(p));
  nand_gate u_q   (.a(nt),  .b(bin), .y(q));
  nand_gate u_bo  (.a(p),   .b(q),   .y(bout));
endmodule

module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  // sa doubles as the result shift register: each consumed minuend bit frees the MSB slot
  // that receives the new difference bit, so after WIDTH shifts sa holds the result.
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic             br_q;
  logic [CntW-1:0]  cnt_q;
  logic             d_bit;
  logic             br_nxt;

  serial_subtractor_cell u_cell (
    .ai  (sa_q[0]),
    .bi  (sb_q[0]),
    .bin (br_q),
    .d   (d_bit),
    .bout(br_nxt)
  );

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE on last bit, DONE -> IDLE always.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == CntLast) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from state; mutually exclusive by construction.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: operand capture, bit-serial shifting, and result publish on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q       <= '0;
      sb_q       <= '0;
      br_q       <= 1'b0;
      cnt_q      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sa_q  <= a;
            sb_q  <= b;
            br_q  <= 1'b0;
            cnt_q <= '0;
          end
        end
        StRun: begin
          sa_q <= {d_bit, sa_q[WIDTH-1:1]};
          sb_q <= sb_q >> 1;
          br_q <= br_nxt;
          if (cnt_q == CntLast) begin
            diff       <= {d_bit, sa_q[WIDTH-1:1]};
            borrow_out <= br_nxt;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8 plus a WIDTH=2 exhaustive sweep).
// Expected results are queued at launch and popped when done is seen.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, borrow_out;
  logic [7:0] diff;

  logic       start2;
  logic [1:0] a2, b2;
  logic       busy2, done2, borrow2;
  logic [1:0] diff2;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow_out(borrow2)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [8:0] exp_q[$];
  logic [2:0] exp2_q[$];
  int         done_cycle[$];
  logic [7:0] hold_diff = 8'h00;
  logic       hold_bo = 1'b0;
  logic [8:0] e;
  logic [2:0] e2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard for the WIDTH=8 instance plus invariants.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_and_done", {31'b0, busy & done}, 32'h0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {31'b0, done}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("diff", {24'b0, diff}, {24'b0, e[7:0]});
          check("borrow_out", {31'b0, borrow_out}, {31'b0, e[8]});
          hold_diff = e[7:0];
          hold_bo   = e[8];
          done_cycle.push_back(cyc);
        end
      end else if (busy) begin
        check("diff_hold_while_busy", {23'b0, borrow_out, diff}, {23'b0, hold_bo, hold_diff});
      end
    end
  end

  // Scoreboard for the WIDTH=2 instance.
  always @(negedge clk) begin
    if (!rst && done2) begin
      if (exp2_q.size() == 0) begin
        check("w2_unexpected_done", {31'b0, done2}, 32'h0);
      end else begin
        e2 = exp2_q.pop_front();
        check("w2_diff_borrow", {29'b0, borrow2, diff2}, {29'b0, e2});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Wait for done with a bound; n = edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv);
    int n;
    int busy_cnt;
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back({(av < bv), 8'(av - bv)});
    tick();  // accept edge
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    busy_cnt = 0;
    n = 0;
    while (!done && n < 30) begin
      if (busy) busy_cnt++;
      tick();
      n++;
    end
    // done appears WIDTH edges after the accept edge (9th cycle counting the accept cycle)
    check("latency", n, 8);
    check("busy_cycles", busy_cnt, 8);
    tick();  // DONE -> IDLE
    check("done_one_cycle", {31'b0, done}, 32'h0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    a = '0; b = '0; a2 = '0; b2 = '0;
    tick();
    tick();
    check("reset_outputs", {21'b0, busy, done, borrow_out, diff}, 32'h0);
    rst = 1'b0;
    tick();

    // Basic operand patterns.
    run_op(8'h5A, 8'h23);
    run_op(8'h23, 8'h5A);
    run_op(8'h00, 8'h01);
    run_op(8'hFF, 8'hFF);
    run_op(8'hFF, 8'h00);

    // start pulsed mid-run must be ignored.
    a = 8'h10; b = 8'h01; start = 1'b1;
    exp_q.push_back({1'b0, 8'h0F});
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    a = 8'h00; b = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check("latency_with_ignored_start", n + 4, 8);
    tick();
    repeat (3) tick();
    check("diff_held_idle", {23'b0, borrow_out, diff}, {23'b0, 1'b0, 8'h0F});
    check("idle_after_ignored", {30'b0, busy, done}, 32'h0);

    // Async reset in the middle of a run.
    a = 8'h42; b = 8'h11; start = 1'b1;
    exp_q.push_back({1'b0, 8'h31});
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_clears", {21'b0, busy, done, borrow_out, diff}, 32'h0);
    exp_q.delete();
    hold_diff = 8'h00;
    hold_bo = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_reset_idle", {21'b0, busy, done, borrow_out, diff}, 32'h0);
    run_op(8'h80, 8'h01);

    // start held high: three back-to-back operations.
    done_cycle.delete();
    start = 1'b1;
    a = 8'h33; b = 8'h11;
    exp_q.push_back({1'b0, 8'h22});
    tick();
    wait_done(n);
    check("b2b_done1", {31'b0, done}, 32'h1);
    a = 8'h11; b = 8'h33;
    exp_q.push_back({1'b1, 8'hDE});
    tick();
    tick();
    wait_done(n);
    check("b2b_done2", {31'b0, done}, 32'h1);
    a = 8'hC8; b = 8'h64;
    exp_q.push_back({1'b0, 8'h64});
    tick();
    tick();
    start = 1'b0;
    wait_done(n);
    check("b2b_done3", {31'b0, done}, 32'h1);
    tick();
    tick();
    check("b2b_done_count", done_cycle.size(), 3);
    if (done_cycle.size() == 3) begin
      check("b2b_spacing_1", done_cycle[1] - done_cycle[0], 10);
      check("b2b_spacing_2", done_cycle[2] - done_cycle[1], 10);
    end
    check("b2b_queue_empty", exp_q.size(), 0);

    // WIDTH=2 exhaustive sweep.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a2 = 2'(i);
        b2 = 2'(j);
        start2 = 1'b1;
        exp2_q.push_back({(i < j), 2'(i - j)});
        tick();
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 10) begin
          tick();
          n++;
        end
        check("w2_latency", n, 2);
        tick();
      end
    end
    check("w2_queue_empty", exp2_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
